// File: rtl/dz_pkg.sv
// ============================================================================
// Module  : dz_pkg
// Purpose : Shared definitions for the dot-matrix driver: colour-mode
//           encoding and the active-low row decode helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dz_pkg;

   // Colour-mode encoding: bit 0 enables green, bit 1 enables red.
   typedef enum logic [1:0] {
      CM_OFF   = 2'b00,
      CM_GREEN = 2'b01,
      CM_RED   = 2'b10,
      CM_BOTH  = 2'b11
   } color_mode_e;

   localparam int unsigned CM_GREEN_BIT = 0;
   localparam int unsigned CM_RED_BIT   = 1;

   // One bit of the one-hot-low row decode: the output bit at bit_pos is
   // driven low (0) only when it is the row currently being scanned.
   function automatic logic row_onehot_low(input int unsigned active_row,
                                           input int unsigned bit_pos);
      return (active_row != bit_pos);
   endfunction

   function automatic logic green_enabled(input logic [1:0] mode);
      return mode[CM_GREEN_BIT];
   endfunction

   function automatic logic red_enabled(input logic [1:0] mode);
      return mode[CM_RED_BIT];
   endfunction

endpackage : dz_pkg

`default_nettype wire

// File: rtl/dz_pattern_ram.sv
// ============================================================================
// Module  : dz_pattern_ram
// Purpose : Pattern storage, DEPTH x WIDTH, one write port and one
//           registered read port. A read and a write to the same word on
//           the same edge return the old contents. Not cleared by reset.
// Ports   : clk      - clock
//           wr_en    - write strobe
//           wr_addr  - write address
//           wr_data  - write data
//           rd_en    - read enable (read register holds when low)
//           rd_addr  - read address
//           rd_data  - registered read data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dz_pattern_ram #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 8,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Separate process: the read samples the pre-edge contents, so a
   // simultaneous write to the same word is not visible until later.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : dz_pattern_ram

`default_nettype wire

// File: rtl/dz_matrix_drv.sv
// ============================================================================
// Module  : dz_matrix_drv
// Purpose : Bi-colour LED dot-matrix scan driver. Scans ROWS rows for DWELL
//           clocks each, fetches the row bitmap of the active frame from a
//           pattern RAM, blanks the first cycle of each row, and applies
//           frame-PWM brightness and optional blinking.
// Ports   : clk         - scan clock
//           rst         - synchronous active-low reset
//           en          - display enable (low blanks, holds at frame start)
//           frame_sel   - pattern to display, taken at frame boundary
//           color_mode  - 00 off, 01 green, 10 red, 11 both
//           brightness  - frame-PWM duty level
//           blink_en    - enables blinking
//           wr_en/wr_frame/wr_row/wr_data - pattern write port
//           row         - active-low one-hot row drive
//           colg/colr   - green / red column drives, active-high
//           frame_start - one-cycle pulse with first output cycle of row 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dz_matrix_drv
   import dz_pkg::*;
#(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int FRAMES       = 16,
   parameter int DWELL        = 4,
   parameter int PWM_BITS     = 2,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [$clog2(FRAMES)-1:0]   frame_sel,
   input  logic [1:0]                  color_mode,
   input  logic [PWM_BITS-1:0]         brightness,
   input  logic                        blink_en,
   input  logic                        wr_en,
   input  logic [$clog2(FRAMES)-1:0]   wr_frame,
   input  logic [$clog2(ROWS)-1:0]     wr_row,
   input  logic [COLS-1:0]             wr_data,
   output logic [ROWS-1:0]             row,
   output logic [COLS-1:0]             colg,
   output logic [COLS-1:0]             colr,
   output logic                        frame_start
);

   localparam int FW    = $clog2(FRAMES);
   localparam int RW    = $clog2(ROWS);
   localparam int DW    = $clog2(DWELL);
   localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int DEPTH = FRAMES * ROWS;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [DW-1:0] D_LAST  = DW'(DWELL - 1);
   localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
   localparam logic [BW-1:0] FC_LAST = BW'(BLINK_FRAMES - 1);
   localparam int unsigned   PWM_LEVELS = 2 ** PWM_BITS;
   localparam int unsigned   BLINK_HALF = BLINK_FRAMES / 2;

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   logic [RW-1:0]   scan_row;
   logic [DW-1:0]   dwell;
   logic [BW-1:0]   frame_cnt;
   logic [FW-1:0]   active_frame;

   // ------------------------------------------------------------------
   // Combinational next-output terms
   // ------------------------------------------------------------------
   logic            row_first;
   logic            frame_last;
   logic            visible;
   logic [COLS-1:0] row_data;
   logic [COLS-1:0] pix;
   logic [ROWS-1:0] row_dec;
   logic            wr_ok;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;
   logic [31:0]     fc_mod;

   assign row_first  = (dwell == '0);
   assign frame_last = (dwell == D_LAST) && (scan_row == R_LAST);

   // Frame-PWM: a frame is lit when its position within the PWM cycle does
   // not exceed the brightness level; the second half of each blink period
   // is dark when blinking is enabled.
   assign fc_mod  = 32'(frame_cnt) % PWM_LEVELS;
   assign visible = (fc_mod <= 32'(brightness)) &&
                    !(blink_en && (32'(frame_cnt) >= BLINK_HALF));

   assign pix = visible ? row_data : '0;

   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
         assign row_dec[gi] = row_onehot_low(32'(scan_row), 32'(gi));
      end
   endgenerate

   // Out-of-range writes (row, or frame when FRAMES is not a power of 2)
   // are dropped so they cannot alias onto another frame's words.
   assign wr_ok   = wr_en && (32'(wr_row) < ROWS) && (32'(wr_frame) < FRAMES);
   assign wr_addr = AW'(32'(wr_frame) * ROWS + 32'(wr_row));
   assign rd_addr = AW'(32'(active_frame) * ROWS + 32'(scan_row));

   // ------------------------------------------------------------------
   // Pattern storage; the read register doubles as the row sample, loaded
   // at the end of each row's blanked d=0 cycle and held for the rest of
   // the dwell.
   // ------------------------------------------------------------------
   dz_pattern_ram #(
      .DEPTH (DEPTH),
      .WIDTH (COLS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (row_first),
      .rd_addr (rd_addr),
      .rd_data (row_data)
   );

   // ------------------------------------------------------------------
   // Scan counters and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_row     <= '0;
         dwell        <= '0;
         frame_cnt    <= '0;
         active_frame <= '0;
         row          <= '1;
         colg         <= '0;
         colr         <= '0;
         frame_start  <= 1'b0;
      end else if (!en) begin
         // Held at frame start so re-enabling begins cleanly at row 0.
         scan_row     <= '0;
         dwell        <= '0;
         frame_cnt    <= '0;
         active_frame <= frame_sel;
         row          <= '1;
         colg         <= '0;
         colr         <= '0;
         frame_start  <= 1'b0;
      end else begin
         row         <= row_dec;
         frame_start <= row_first && (scan_row == '0);

         // First cycle of every row is blanked to avoid ghosting while the
         // row drivers switch.
         if (row_first) begin
            colg <= '0;
            colr <= '0;
         end else begin
            colg <= green_enabled(color_mode) ? pix : '0;
            colr <= red_enabled(color_mode)   ? pix : '0;
         end

         if (dwell == D_LAST) begin
            dwell <= '0;
            if (scan_row == R_LAST) begin
               scan_row <= '0;
               frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
            end else begin
               scan_row <= scan_row + 1'b1;
            end
         end else begin
            dwell <= dwell + 1'b1;
         end

         // Frame selection only changes between frames, so no tearing.
         if (frame_last) begin
            active_frame <= frame_sel;
         end
      end
   end

endmodule : dz_matrix_drv

`default_nettype wire

// File: tb/tb_dz_matrix_drv.sv
// ============================================================================
// Module  : tb_dz_matrix_drv
// Purpose : Self-checking bench for dz_matrix_drv. A timeline model derives
//           row, dwell and frame number from the count of enabled cycles
//           and predicts every output cycle.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dz_matrix_drv;

   localparam int ROWS         = 8;
   localparam int COLS         = 8;
   localparam int FRAMES       = 16;
   localparam int DWELL        = 4;
   localparam int PWM_BITS     = 2;
   localparam int BLINK_FRAMES = 32;
   localparam int FW           = $clog2(FRAMES);
   localparam int RW           = $clog2(ROWS);
   localparam int FRAME_LEN    = DWELL * ROWS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                en;
   logic [FW-1:0]       frame_sel;
   logic [1:0]          color_mode;
   logic [PWM_BITS-1:0] brightness;
   logic                blink_en;
   logic                wr_en;
   logic [FW-1:0]       wr_frame;
   logic [RW-1:0]       wr_row;
   logic [COLS-1:0]     wr_data;
   logic [ROWS-1:0]     row;
   logic [COLS-1:0]     colg;
   logic [COLS-1:0]     colr;
   logic                frame_start;

   dz_matrix_drv #(
      .ROWS         (ROWS),
      .COLS         (COLS),
      .FRAMES       (FRAMES),
      .DWELL        (DWELL),
      .PWM_BITS     (PWM_BITS),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .frame_sel   (frame_sel),
      .color_mode  (color_mode),
      .brightness  (brightness),
      .blink_en    (blink_en),
      .wr_en       (wr_en),
      .wr_frame    (wr_frame),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .row         (row),
      .colg        (colg),
      .colr        (colr),
      .frame_start (frame_start)
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   logic [COLS-1:0] mem [FRAMES][ROWS];
   int              steps;      // enabled cycles since scan restart
   int              act;        // frame being displayed
   logic [COLS-1:0] samp;       // bitmap latched for the current row
   logic [ROWS-1:0] e_row;
   logic [COLS-1:0] e_g;
   logic [COLS-1:0] e_r;
   logic            e_fs;

   int vectors     = 0;
   int miscompares = 0;

   function automatic int cur_row();
      return (steps / DWELL) % ROWS;
   endfunction

   function automatic int cur_dwell();
      return steps % DWELL;
   endfunction

   // Predict the outputs produced by the coming clock edge.
   task automatic model_edge();
      int  r;
      int  d;
      int  fc;
      logic vis;
      if (!rst) begin
         e_row = '1; e_g = '0; e_r = '0; e_fs = 1'b0;
         steps = 0;
         act   = 0;
      end else if (!en) begin
         e_row = '1; e_g = '0; e_r = '0; e_fs = 1'b0;
         steps = 0;
         act   = int'(frame_sel);
      end else begin
         r  = cur_row();
         d  = cur_dwell();
         fc = (steps / FRAME_LEN) % BLINK_FRAMES;
         e_row = ~(ROWS'(1) << r);
         e_fs  = (r == 0) && (d == 0);
         if (d == 0) begin
            samp = mem[act][r];
            e_g  = '0;
            e_r  = '0;
         end else begin
            vis = ((fc % (1 << PWM_BITS)) <= int'(brightness)) &&
                  !(blink_en && (fc >= BLINK_FRAMES / 2));
            e_g = (vis && color_mode[0]) ? samp : '0;
            e_r = (vis && color_mode[1]) ? samp : '0;
         end
         if ((d == DWELL - 1) && (r == ROWS - 1)) act = int'(frame_sel);
         steps++;
      end
      if (wr_en && (int'(wr_row) < ROWS)) mem[wr_frame][wr_row] = wr_data;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: inputs already set; model and DUT advance; compare at negedge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("row",         64'(row),         64'(e_row));
      check("colg",        64'(colg),        64'(e_g));
      check("colr",        64'(colr),        64'(e_r));
      check("frame_start", 64'(frame_start), 64'(e_fs));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Advance until the model sits at (r,d); bounded.
   task automatic run_to(input int r, input int d);
      for (int i = 0; i < 2 * FRAME_LEN; i++) begin
         if (cur_row() == r && cur_dwell() == d) return;
         cycle();
      end
      check("run_to_timeout", 64'(cur_row()), 64'(r));
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; frame_sel = '0; color_mode = 2'b00;
      brightness = '0; blink_en = 1'b0; wr_en = 1'b0; wr_frame = '0;
      wr_row = '0; wr_data = '0;
      steps = 0; act = 0; samp = '0;
      @(negedge clk);

      // Reset state
      run(3);
      check("reset_row", 64'(row), 64'hFF);

      // Load all patterns while disabled; frame 0 is the 8'h18 bar
      rst = 1'b1;
      for (int f = 0; f < FRAMES; f++) begin
         for (int r = 0; r < ROWS; r++) begin
            wr_en = 1'b1; wr_frame = FW'(f); wr_row = RW'(r);
            wr_data = (f == 0) ? 8'h18 : COLS'($urandom);
            cycle();
         end
      end
      wr_en = 1'b0;

      // Green, full brightness, frame 0
      en = 1'b1; color_mode = 2'b01; brightness = 2'd3; frame_sel = '0;
      cycle();
      check("en_rise_row", 64'(row), 64'hFE);
      check("en_rise_fs", 64'(frame_start), 64'd1);
      check("en_rise_colg", 64'(colg), 64'h00);
      cycle();
      check("bar_colg", 64'(colg), 64'h18);
      run(2 * FRAME_LEN);

      // Frame switch requested mid-frame (row 3)
      run_to(3, 1);
      frame_sel = FW'(1);
      run(2 * FRAME_LEN);

      // PWM brightness 1, both colours
      brightness = 2'd1; color_mode = 2'b11; frame_sel = FW'($urandom);
      run(5 * FRAME_LEN);

      // Blinking over a full period plus wrap
      brightness = 2'd3; blink_en = 1'b1; color_mode = 2'b01;
      run(34 * FRAME_LEN);
      blink_en = 1'b0;

      // Reset in row 5, d=2
      run_to(5, 2);
      rst = 1'b0;
      cycle();
      check("midrow_rst_row", 64'(row), 64'hFF);
      check("midrow_rst_cols", 64'({colg, colr}), 64'h0);
      rst = 1'b1;
      cycle();
      check("post_rst_row", 64'(row), 64'hFE);
      check("post_rst_fs", 64'(frame_start), 64'd1);

      // Write to the displayed row at its d=0 cycle
      run(FRAME_LEN);
      run_to(2, 0);
      wr_en = 1'b1; wr_frame = FW'(act); wr_row = RW'(2);
      wr_data = ~mem[act][2];
      cycle();
      wr_en = 1'b0;
      run(2 * FRAME_LEN);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 49) == 0) frame_sel = FW'($urandom);
         if ($urandom_range(0, 99) == 0) color_mode = 2'($urandom);
         if ($urandom_range(0, 99) == 0) brightness = PWM_BITS'($urandom);
         if ($urandom_range(0, 149) == 0) blink_en = ~blink_en;
         wr_en    = rst && ($urandom_range(0, 3) == 0);
         wr_frame = FW'($urandom);
         wr_row   = RW'($urandom);
         wr_data  = COLS'($urandom);
         cycle();
      end
      rst = 1'b1; wr_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_dz_matrix_drv

`default_nettype wire
